// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   IF stage of a 5-stage RV32 pipeline. It holds the PC and drives the
//   instruction memory. It also fills the IF/ID pipeline register and
//   handles branch redirects, load-use stalls and memory wait states.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   NOP_INSTR      bubble encoding written into IF/ID
//
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous, active-high
//   BRANCH_TAKEN   redirect request from EX
//   BRANCH_TARGET  redirect address (bits [1:0] ignored)
//   STALL          load-use hold from the hazard unit
//   IMEM_READ      instruction memory read strobe (registered)
//   IMEM_ADDR      instruction memory address (= PC register)
//   IMEM_READDATA  fetched instruction
//   IMEM_BUSYWAIT  memory not ready, current access continues
//   IF_ID_PC       PC of the instruction held in IF/ID
//   IF_ID_PC4      IF_ID_PC + 4
//   IF_ID_INSTR    instruction held in IF/ID
//   IF_ID_VALID    1 = real instruction, 0 = bubble
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REDIRECT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic        unused_target_lsbs;

  assign IMEM_ADDR          = pc;
  assign target_aligned     = {BRANCH_TARGET[31:2], 2'b00};
  assign pc_plus4           = pc + 32'd4;
  assign unused_target_lsbs = ^BRANCH_TARGET[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redir_pc    <= '0;
      IMEM_READ   <= 1'b0;
      IF_ID_PC    <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          IMEM_READ <= 1'b1;
        end

        FETCH: begin
          IMEM_READ <= 1'b1;
          if (BRANCH_TAKEN) begin
            IF_ID_INSTR <= NOP_INSTR;
            IF_ID_VALID <= 1'b0;
            if (!IMEM_BUSYWAIT) begin
              pc <= target_aligned;
            end else begin
              // The access to pc is still in flight. Park the target
              // until it completes.
              redir_pc <= target_aligned;
              state    <= REDIRECT;
            end
          end else if (IMEM_BUSYWAIT) begin
            if (!STALL) begin
              IF_ID_INSTR <= NOP_INSTR;
              IF_ID_VALID <= 1'b0;
            end
          end else if (!STALL) begin
            IF_ID_PC    <= pc;
            IF_ID_PC4   <= pc_plus4;
            IF_ID_INSTR <= IMEM_READDATA;
            IF_ID_VALID <= 1'b1;
            pc          <= pc_plus4;
          end
        end

        REDIRECT: begin
          IMEM_READ   <= 1'b1;
          IF_ID_INSTR <= NOP_INSTR;
          IF_ID_VALID <= 1'b0;
          if (BRANCH_TAKEN) begin
            redir_pc <= target_aligned;
          end
          if (!IMEM_BUSYWAIT) begin
            // Data from the stale access is dropped. A branch arriving
            // on the same edge is newer than the parked target.
            pc    <= BRANCH_TAKEN ? target_aligned : redir_pc;
            state <= FETCH;
          end
        end

        default: begin
          state     <= IDLE;
          IMEM_READ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed test of instruction_fetch_unit. A combinational memory model
//   returns a known word for every address.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int unsigned checks;
  int unsigned failures;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .BRANCH_TAKEN (branch_taken),
    .BRANCH_TARGET(branch_target),
    .STALL        (stall),
    .IMEM_READ    (imem_read),
    .IMEM_ADDR    (imem_addr),
    .IMEM_READDATA(imem_readdata),
    .IMEM_BUSYWAIT(imem_busywait),
    .IF_ID_PC     (if_id_pc),
    .IF_ID_PC4    (if_id_pc4),
    .IF_ID_INSTR  (if_id_instr),
    .IF_ID_VALID  (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00A0_0093 : {16'hC0DE, a[15:0]};
  endfunction

  assign imem_readdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic stl, input logic bw);
    branch_taken  = br;
    branch_target = tgt;
    stall         = stl;
    imem_busywait = bw;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    check({tag, "_instr"}, if_id_instr, NOP);
  endtask

  task automatic check_valid(input string tag, input logic [31:0] pc);
    check({tag, "_pc"}, if_id_pc, pc);
    check({tag, "_pc4"}, if_id_pc4, pc + 32'd4);
    check({tag, "_instr"}, if_id_instr, mem_word(pc));
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"}, {31'b0, imem_read}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_pc"}, if_id_pc, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_instr"}, if_id_instr, NOP);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
  endtask

  // A zero-wait branch lands PC on tgt with a bubble in IF/ID.
  task automatic jump(input logic [31:0] tgt);
    drive(1'b1, tgt, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset values
    step();
    step();
    check_reset_state("rst");

    // First fetch after release
    reset = 1'b0;
    step();
    check("idle_read", {31'b0, imem_read}, 32'd1);
    check("idle_addr", imem_addr, 32'h0);
    check("idle_valid", {31'b0, if_id_valid}, 32'd0);
    step();
    check_valid("first", 32'h0);
    check("first_addr", imem_addr, 32'h4);

    // Branch to 0x0C and advance, so that PC = 0x10 with 0x0C in IF/ID.
    jump(32'h0000_000C);
    check("br_c_addr", imem_addr, 32'hC);
    check_bubble("br_c");
    step();
    check_valid("adv_c", 32'hC);

    // Stall two cycles at PC = 0x10.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_valid("stall_hold", 32'hC);
      check("stall_addr", imem_addr, 32'h10);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_valid("stall_rel", 32'h10);
    check("stall_rel_addr", imem_addr, 32'h14);

    // Busywait for three cycles at PC = 0x20.
    jump(32'h0000_0020);
    step();
    check_valid("pre_bw", 32'h20);
    jump(32'h0000_0020);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      check_bubble("bw");
      check("bw_pc_held", if_id_pc, 32'h20);
      check("bw_addr", imem_addr, 32'h20);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_valid("bw_rel", 32'h20);
    check("bw_rel_addr", imem_addr, 32'h24);

    // A branch wins over a stall and drops the low bits of the target.
    jump(32'h0000_0040);
    drive(1'b1, 32'h0000_0103, 1'b1, 1'b0);
    step();
    check_bubble("br_stall");
    check("br_stall_addr", imem_addr, 32'h100);

    // A branch during a busywait goes through REDIRECT. It stalls there,
    // and the data for 0x40 never becomes valid.
    jump(32'h0000_0040);
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    step();
    check_bubble("redir0");
    check("redir0_addr", imem_addr, 32'h40);
    check("redir0_read", {31'b0, imem_read}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_bubble("redir1");
    check("redir1_addr", imem_addr, 32'h40);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_bubble("redir_exit");
    check("redir_exit_addr", imem_addr, 32'h200);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_valid("redir_after", 32'h200);

    // A second branch while in REDIRECT replaces the parked target.
    drive(1'b1, 32'h0000_0280, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h0000_0302, 1'b0, 1'b1);
    step();
    check_bubble("redir_ow");
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("redir_ow_addr", imem_addr, 32'h300);

    // PC wraps past the top of the address space.
    jump(32'hFFFF_FFFC);
    step();
    check_valid("wrap", 32'hFFFF_FFFC);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while in REDIRECT drops the pending target.
    drive(1'b1, 32'h0000_0080, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h0000_0080, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    check_reset_state("rst_redir");
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("post_rst_read", {31'b0, imem_read}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    step();
    check_valid("post_rst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
